// File: rtl/tl_get_arbiter.sv
// tl_get_arbiter: round-robin arbiter and source-ID allocator in front of a
// shared TileLink A-channel Get queue. It grants at most one requester per
// cycle, tags the beat with the lowest free source ID, retires IDs on D-channel
// responses and steers each response back to the requester that issued it.
//
// Ports:
//   clock, reset      sole clock; synchronous active-high reset
//   io_req_valid      per-requester request valid
//   io_req_ready      per-requester accept (one-hot or zero)
//   io_req_address    per-requester 33-bit address, requester i at [33i+32:33i]
//   io_req_param      per-requester 3-bit A param, requester i at [3i+2:3i]
//   io_a_valid/ready  enqueue handshake to the A queue
//   io_a_param        param of the granted requester
//   io_a_source       allocated source ID
//   io_a_address      address of the granted requester
//   io_d_valid        single-beat D response, always accepted
//   io_d_source       source ID of the response
//   io_d_owner        one-hot owner of io_d_source while a valid in-flight beat
//   io_err_spurious   sticky flag: D beat for a source that was not in flight
module tl_get_arbiter #(
   parameter int unsigned NREQ        = 3,
   parameter int unsigned NSRC        = 8,
   parameter int unsigned MAX_PER_REQ = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      io_req_valid,
   output logic [NREQ-1:0]      io_req_ready,
   input  logic [NREQ*33-1:0]   io_req_address,
   input  logic [NREQ*3-1:0]    io_req_param,
   output logic                 io_a_valid,
   input  logic                 io_a_ready,
   output logic [2:0]           io_a_param,
   output logic [2:0]           io_a_source,
   output logic [32:0]          io_a_address,
   input  logic                 io_d_valid,
   input  logic [2:0]           io_d_source,
   output logic [NREQ-1:0]      io_d_owner,
   output logic                 io_err_spurious
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(MAX_PER_REQ + 1);
   localparam int unsigned SW = 3;
   localparam int unsigned AW = 33;
   localparam int unsigned PW = 3;

   // Registered state
   logic [NSRC-1:0]  free;
   logic [IW-1:0]    owner [NSRC];
   logic [CW-1:0]    cnt   [NREQ];
   logic [IW-1:0]    rr_ptr;
   logic             locked;
   logic [IW-1:0]    lock_idx;
   logic [SW-1:0]    lock_src;
   logic             err;

   // Combinational decode
   logic             any_free;
   logic [SW-1:0]    low_src;
   logic [NREQ-1:0]  eligible;
   logic             gnt_valid;
   logic [IW-1:0]    gnt_idx;
   logic [SW-1:0]    a_src;
   logic             fire;
   logic [IW-1:0]    rr_nxt;
   logic             d_hit;
   logic [IW-1:0]    d_idx;
   logic [CW-1:0]    cnt_nxt [NREQ];

   assign any_free = |free;

   // Lowest-index free source ID from the registered pool
   always_comb begin
      low_src = '0;
      for (int s = int'(NSRC) - 1; s >= 0; s--) begin
         if (free[s]) low_src = SW'(s);
      end
   end

   // Per-requester eligibility: valid, below the in-flight cap, pool non-empty
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         eligible[i] = io_req_valid[i] && (cnt[i] < CW'(MAX_PER_REQ)) && any_free;
      end
   end

   // Grant: a stalled beat keeps its requester; otherwise rotate from rr_ptr
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (locked) begin
         gnt_valid = 1'b1;
         gnt_idx   = lock_idx;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_valid && eligible[IW'((32'(rr_ptr) + k) % NREQ)]) begin
               gnt_valid = 1'b1;
               gnt_idx   = IW'((32'(rr_ptr) + k) % NREQ);
            end
         end
      end
   end

   // A stalled beat keeps the ID it was offered so the payload stays stable
   // even if a lower ID is retired while waiting.
   assign a_src  = locked ? lock_src : low_src;
   assign fire   = gnt_valid && io_a_ready;
   assign rr_nxt = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);

   assign io_a_valid   = gnt_valid;
   assign io_a_source  = a_src;
   assign io_a_address = io_req_address[32'(gnt_idx) * AW +: AW];
   assign io_a_param   = io_req_param[32'(gnt_idx) * PW +: PW];

   always_comb begin
      io_req_ready = '0;
      if (fire) io_req_ready[gnt_idx] = 1'b1;
   end

   // D beat retires an ID only if it is actually in flight
   assign d_hit = io_d_valid && !free[io_d_source];
   assign d_idx = owner[io_d_source];

   always_comb begin
      io_d_owner = '0;
      if (d_hit) io_d_owner[d_idx] = 1'b1;
   end

   assign io_err_spurious = err;

   // In-flight counts; a fire and a retire for the same requester cancel out
   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         cnt_nxt[i] = cnt[i];
         if (fire && (gnt_idx == IW'(i))) cnt_nxt[i] = cnt_nxt[i] + CW'(1);
         if (d_hit && (d_idx == IW'(i)))  cnt_nxt[i] = cnt_nxt[i] - CW'(1);
      end
   end

   // State update; fire only clears a free ID and a D hit only sets a busy one,
   // so the two pool writes never target the same bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         free     <= '1;
         for (int unsigned s = 0; s < NSRC; s++) owner[s] <= '0;
         for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
         rr_ptr   <= '0;
         locked   <= 1'b0;
         lock_idx <= '0;
         lock_src <= '0;
         err      <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= cnt_nxt[i];
         if (d_hit) free[io_d_source] <= 1'b1;
         if (io_d_valid && free[io_d_source]) err <= 1'b1;
         if (fire) begin
            free[a_src]  <= 1'b0;
            owner[a_src] <= gnt_idx;
            rr_ptr       <= rr_nxt;
            locked       <= 1'b0;
         end else if (gnt_valid) begin
            locked   <= 1'b1;
            lock_idx <= gnt_idx;
            lock_src <= a_src;
         end
      end
   end

endmodule

// File: tb/tb_tl_get_arbiter.sv
// Testbench for tl_get_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the ID pool.
module tb_tl_get_arbiter;

   localparam int NREQ = 3;
   localparam int NSRC = 8;
   localparam int MAXR = 4;

   logic                clock = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     io_req_valid;
   logic [NREQ-1:0]     io_req_ready;
   logic [NREQ*33-1:0]  io_req_address;
   logic [NREQ*3-1:0]   io_req_param;
   logic                io_a_valid;
   logic                io_a_ready;
   logic [2:0]          io_a_param;
   logic [2:0]          io_a_source;
   logic [32:0]         io_a_address;
   logic                io_d_valid;
   logic [2:0]          io_d_source;
   logic [NREQ-1:0]     io_d_owner;
   logic                io_err_spurious;

   tl_get_arbiter #(.NREQ(NREQ), .NSRC(NSRC), .MAX_PER_REQ(MAXR)) dut (
      .clock           (clock),
      .reset           (reset),
      .io_req_valid    (io_req_valid),
      .io_req_ready    (io_req_ready),
      .io_req_address  (io_req_address),
      .io_req_param    (io_req_param),
      .io_a_valid      (io_a_valid),
      .io_a_ready      (io_a_ready),
      .io_a_param      (io_a_param),
      .io_a_source     (io_a_source),
      .io_a_address    (io_a_address),
      .io_d_valid      (io_d_valid),
      .io_d_source     (io_d_source),
      .io_d_owner      (io_d_owner),
      .io_err_spurious (io_err_spurious)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Requester stimulus
   logic        req_v [NREQ];
   logic [32:0] req_a [NREQ];
   logic [2:0]  req_p [NREQ];

   // Model: owner_of[id] = requester holding the ID, -1 when free
   int  owner_of [NSRC];
   int  m_cnt [NREQ];
   int  m_rr;
   bit  m_locked;
   int  m_lock_idx;
   int  m_lock_src;
   bit  m_err;

   // Model predictions for the current cycle
   bit              e_valid;
   int              e_g;
   int              e_src;
   bit              e_fire;
   logic [NREQ-1:0] e_ready;
   logic [NREQ-1:0] e_downer;
   bit              e_dhit;
   int              e_down;

   // Observed outputs of the current cycle
   logic            o_valid;
   logic [NREQ-1:0] o_ready;
   logic [NREQ-1:0] o_downer;
   logic [2:0]      o_src;
   logic [2:0]      o_param;
   logic [32:0]     o_addr;
   logic            o_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NSRC; s++) owner_of[s] = -1;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      m_rr = 0;
      m_locked = 0;
      m_lock_idx = 0;
      m_lock_src = 0;
      m_err = 0;
   endtask

   task automatic model_eval();
      int lowest;
      lowest = -1;
      for (int s = 0; s < NSRC; s++)
         if (owner_of[s] == -1 && lowest < 0) lowest = s;
      e_valid = 0;
      e_g = 0;
      e_src = 0;
      if (m_locked) begin
         e_valid = 1;
         e_g = m_lock_idx;
         e_src = m_lock_src;
      end else if (lowest >= 0) begin
         e_src = lowest;
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (!e_valid && req_v[i] && m_cnt[i] < MAXR) begin
               e_valid = 1;
               e_g = i;
            end
         end
      end
      e_fire = e_valid && io_a_ready;
      e_ready = '0;
      if (e_fire) e_ready[e_g] = 1'b1;
      e_dhit = io_d_valid && owner_of[io_d_source] != -1;
      e_down = e_dhit ? owner_of[io_d_source] : 0;
      e_downer = '0;
      if (e_dhit) e_downer[e_down] = 1'b1;
   endtask

   task automatic model_commit();
      if (reset) begin
         model_reset();
      end else begin
         if (io_d_valid) begin
            if (e_dhit) begin
               owner_of[io_d_source] = -1;
               m_cnt[e_down]--;
            end else begin
               m_err = 1;
            end
         end
         if (e_fire) begin
            owner_of[e_src] = e_g;
            m_cnt[e_g]++;
            m_rr = (e_g + 1) % NREQ;
            m_locked = 0;
         end else if (e_valid) begin
            m_locked = 1;
            m_lock_idx = e_g;
            m_lock_src = e_src;
         end
      end
   endtask

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         io_req_valid[i] = req_v[i];
         io_req_address[i*33 +: 33] = req_a[i];
         io_req_param[i*3 +: 3] = req_p[i];
      end
   endtask

   // One clock: drive, sample mid-cycle, compare to model, advance both
   task automatic cycle(input bit do_check);
      apply();
      #1;
      model_eval();
      o_valid  = io_a_valid;
      o_ready  = io_req_ready;
      o_downer = io_d_owner;
      o_src    = io_a_source;
      o_param  = io_a_param;
      o_addr   = io_a_address;
      o_err    = io_err_spurious;
      if (do_check) begin
         check("a_valid", 64'(o_valid), 64'(e_valid));
         check("req_ready", 64'(o_ready), 64'(e_ready));
         if (e_valid) begin
            check("a_source", 64'(o_src), 64'(e_src));
            check("a_address", 64'(o_addr), 64'(req_a[e_g]));
            check("a_param", 64'(o_param), 64'(req_p[e_g]));
         end
         check("d_owner", 64'(o_downer), 64'(e_downer));
         check("err_spurious", 64'(o_err), 64'(m_err));
      end
      @(posedge clock);
      model_commit();
      #1;
   endtask

   task automatic idle();
      for (int i = 0; i < NREQ; i++) begin
         req_v[i] = 1'b0;
         req_a[i] = 33'(64'h1_0000_0000 + 64'(i) * 64'h100);
         req_p[i] = 3'(i + 1);
      end
      io_a_ready  = 1'b0;
      io_d_valid  = 1'b0;
      io_d_source = 3'd0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cycle(1);
      reset = 1'b0;
   endtask

   initial begin
      int cand [$];
      idle();
      model_reset();
      reset = 1'b1;
      cycle(0);
      cycle(0);
      reset = 1'b0;

      // Reset state with no valid inputs
      cycle(1);
      check("rst_a_valid", 64'(o_valid), 64'd0);
      check("rst_req_ready", 64'(o_ready), 64'd0);
      check("rst_d_owner", 64'(o_downer), 64'd0);
      check("rst_err", 64'(o_err), 64'd0);

      // First Get: same-cycle fire with source 0
      req_v[0] = 1'b1; req_a[0] = 33'h1_0000_0040; req_p[0] = 3'd4;
      io_a_ready = 1'b1;
      cycle(1);
      check("first_fire", 64'(o_ready), 64'b001);
      check("first_src", 64'(o_src), 64'd0);
      check("first_addr", 64'(o_addr), 64'h1_0000_0040);
      req_v[0] = 1'b0;
      cycle(1);
      // Pointer moved to 1 and ID 0 is taken
      req_v[0] = 1'b1; req_v[1] = 1'b1;
      cycle(1);
      check("rr_after_first", 64'(o_ready), 64'b010);
      check("src_after_first", 64'(o_src), 64'd1);

      // Round-robin over three requesters
      do_reset();
      for (int i = 0; i < NREQ; i++) req_v[i] = 1'b1;
      io_a_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle(1);
         check("rr_grant", 64'(o_ready), 64'(1 << (k % 3)));
         check("rr_src", 64'(o_src), 64'(k));
      end

      // Stall holds grant, source and payload
      do_reset();
      req_v[1] = 1'b1; req_v[2] = 1'b1;
      io_a_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle(1);
         check("stall_valid", 64'(o_valid), 64'd1);
         check("stall_ready", 64'(o_ready), 64'd0);
         check("stall_src", 64'(o_src), 64'd0);
         check("stall_addr", 64'(o_addr), 64'(req_a[1]));
      end
      io_a_ready = 1'b1;
      cycle(1);
      check("stall_fire", 64'(o_ready), 64'b010);
      req_v[1] = 1'b0;
      cycle(1);
      check("after_stall_grant", 64'(o_ready), 64'b100);
      check("after_stall_src", 64'(o_src), 64'd1);

      // Per-requester cap, retire and re-issue with the retired ID
      do_reset();
      req_v[0] = 1'b1;
      io_a_ready = 1'b1;
      for (int k = 0; k < 4; k++) cycle(1);
      io_d_valid = 1'b1; io_d_source = 3'd2;
      cycle(1);
      check("cap_no_grant", 64'(o_valid), 64'd0);
      check("cap_d_owner", 64'(o_downer), 64'b001);
      io_d_valid = 1'b0;
      cycle(1);
      check("cap_refire", 64'(o_ready), 64'b001);
      check("cap_refire_src", 64'(o_src), 64'd2);

      // Empty pool: freed ID usable only the following cycle
      do_reset();
      for (int i = 0; i < NREQ; i++) req_v[i] = 1'b1;
      io_a_ready = 1'b1;
      for (int k = 0; k < 8; k++) cycle(1);
      io_d_valid = 1'b1; io_d_source = 3'd7;
      cycle(1);
      check("empty_no_grant", 64'(o_valid), 64'd0);
      check("empty_d_owner", 64'(o_downer), 64'b010);
      io_d_valid = 1'b0;
      cycle(1);
      check("empty_refill_src", 64'(o_src), 64'd7);
      check("empty_refill_grant", 64'(o_ready), 64'b100);

      // Spurious D beat is sticky until reset
      do_reset();
      io_d_valid = 1'b1; io_d_source = 3'd5;
      cycle(1);
      check("spur_d_owner", 64'(o_downer), 64'd0);
      check("spur_err_same", 64'(o_err), 64'd0);
      io_d_valid = 1'b0;
      cycle(1);
      check("spur_err_set", 64'(o_err), 64'd1);
      cycle(1);
      check("spur_err_hold", 64'(o_err), 64'd1);
      do_reset();
      cycle(1);
      check("spur_err_clr", 64'(o_err), 64'd0);

      // Reset mid-stall drops the lock and forgets in-flight IDs
      do_reset();
      req_v[0] = 1'b1;
      io_a_ready = 1'b1;
      cycle(1);
      io_a_ready = 1'b0;
      cycle(1);
      req_v[0] = 1'b0;
      reset = 1'b1;
      cycle(1);
      reset = 1'b0;
      cycle(1);
      check("rst_lock_dropped", 64'(o_valid), 64'd0);
      io_d_valid = 1'b1; io_d_source = 3'd0;
      cycle(1);
      check("rst_forgot_owner", 64'(o_downer), 64'd0);
      io_d_valid = 1'b0;
      cycle(1);
      check("rst_forgot_err", 64'(o_err), 64'd1);

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_v[i] && ($urandom % 2 == 0)) begin
               req_v[i] = 1'b1;
               req_a[i] = {1'($urandom), $urandom};
               req_p[i] = 3'($urandom);
            end
         end
         io_a_ready = ($urandom % 4) != 0;
         io_d_valid = 1'b0;
         case ($urandom % 10)
            0, 1, 2, 3: begin
               cand.delete();
               for (int s = 0; s < NSRC; s++) if (owner_of[s] != -1) cand.push_back(s);
               if (cand.size() > 0) begin
                  io_d_valid  = 1'b1;
                  io_d_source = 3'(cand[$urandom % cand.size()]);
               end
            end
            4: begin
               io_d_valid  = 1'b1;
               io_d_source = 3'($urandom);
            end
            default: ;
         endcase
         cycle(1);
         for (int i = 0; i < NREQ; i++) if (e_ready[i]) req_v[i] = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
